// File: rtl/mem_stage_access_unit.sv
// M-stage load/store engine: issues byte-enabled memory or memory-mapped IO accesses,
// stalls the pipeline until the handshake completes, returns extended load data and faults.
module mem_stage_access_unit #(
    parameter int          NUM_IO     = 2,
    parameter logic [31:0] IO_BASE    = 32'h0000_7F00,
    parameter int          IO_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    input  logic [1:0]             be_op,
    input  logic [2:0]             me_op,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    output logic                   stall,
    output logic                   done,
    output logic [31:0]            rdata,
    output logic                   exc_adel,
    output logic                   exc_ades,
    output logic                   exc_bus,
    output logic                   mem_en,
    output logic [3:0]             mem_we,
    output logic [29:0]            mem_addr,
    output logic [31:0]            mem_wdata,
    input  logic [31:0]            mem_rdata,
    input  logic                   mem_ready,
    output logic [NUM_IO-1:0]      io_sel,
    output logic                   io_we,
    output logic [1:0]             io_addr,
    output logic [31:0]            io_wdata,
    input  logic [32*NUM_IO-1:0]   io_rdata,
    input  logic [NUM_IO-1:0]      io_ack
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t state_q, state_d;

    logic              is_store, is_load, op_valid;
    logic              sz_byte, sz_half, sz_word;
    logic [31:0]       io_off;
    logic              in_io;
    logic [NUM_IO-1:0] sel_dec;
    logic              fault;
    logic [3:0]        be_dec;
    logic [31:0]       wdata_rep;

    // Context of the in-flight access
    logic              is_io_q, is_store_q;
    logic [2:0]        ld_op_q;
    logic [1:0]        lo_q;
    logic [7:0]        tmo_q;

    logic [31:0]       io_word;
    logic              io_hit, bus_hit, bus_tmo;

    // Store wins when both op fields are set
    assign is_store = (be_op != 2'b00);
    assign is_load  = !is_store && (me_op >= 3'd1) && (me_op <= 3'd5);
    assign op_valid = req_valid && (is_store || is_load);

    always_comb begin
        sz_byte = 1'b0;
        sz_half = 1'b0;
        sz_word = 1'b0;
        if (is_store) begin
            case (be_op)
                2'b01:   sz_byte = 1'b1;
                2'b10:   sz_half = 1'b1;
                default: sz_word = 1'b1;
            endcase
        end else if (is_load) begin
            case (me_op)
                3'd1, 3'd2: sz_byte = 1'b1;
                3'd3, 3'd4: sz_half = 1'b1;
                default:    sz_word = 1'b1;
            endcase
        end
    end

    assign io_off = addr - IO_BASE;
    assign in_io  = (addr >= IO_BASE) && (io_off < 32'(16 * NUM_IO));

    always_comb begin
        sel_dec = '0;
        for (int k = 0; k < NUM_IO; k++)
            sel_dec[k] = in_io && (io_off[31:4] == 28'(k));
    end

    // IO channels only accept whole words
    assign fault = (sz_half && addr[0]) ||
                   (sz_word && (addr[1:0] != 2'b00)) ||
                   (in_io && !sz_word);

    always_comb begin
        be_dec    = 4'b0000;
        wdata_rep = wdata;
        if (is_store) begin
            if (sz_byte) begin
                be_dec    = 4'b0001 << addr[1:0];
                wdata_rep = {4{wdata[7:0]}};
            end else if (sz_half) begin
                be_dec    = 4'b0011 << {addr[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
            end else begin
                be_dec    = 4'b1111;
            end
        end
    end

    always_comb begin
        io_word = '0;
        for (int k = 0; k < NUM_IO; k++)
            if (io_sel[k]) io_word = io_word | io_rdata[32*k +: 32];
    end

    assign io_hit  = |(io_ack & io_sel);
    assign bus_hit = is_io_q ? io_hit : mem_ready;
    // Last allowed wait cycle: an ack here still wins over the timeout
    assign bus_tmo = is_io_q && !io_hit && (tmo_q == 8'd1);

    function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] lo,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lo, 3'b000} +: 8];
        h = w[{lo[1], 4'b0000} +: 16];
        case (op)
            3'd1:    return {{24{b[7]}}, b};
            3'd2:    return {24'h0, b};
            3'd3:    return {{16{h[15]}}, h};
            3'd4:    return {16'h0, h};
            default: return w;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (op_valid) state_d = fault ? S_RESP : S_BUS;
            S_BUS:   if (bus_hit || bus_tmo) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign done  = (state_q == S_RESP);
    assign stall = reset_n && op_valid && !done;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata      <= '0;
            exc_adel   <= 1'b0;
            exc_ades   <= 1'b0;
            exc_bus    <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            io_sel     <= '0;
            io_we      <= 1'b0;
            io_addr    <= '0;
            io_wdata   <= '0;
            is_io_q    <= 1'b0;
            is_store_q <= 1'b0;
            ld_op_q    <= '0;
            lo_q       <= '0;
            tmo_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (op_valid) begin
                        is_io_q    <= in_io;
                        is_store_q <= is_store;
                        ld_op_q    <= me_op;
                        lo_q       <= addr[1:0];
                        rdata      <= '0;
                        exc_adel   <= fault && is_load;
                        exc_ades   <= fault && is_store;
                        if (!fault) begin
                            if (in_io) begin
                                io_sel   <= sel_dec;
                                io_we    <= is_store;
                                io_addr  <= addr[3:2];
                                io_wdata <= wdata_rep;
                                tmo_q    <= 8'(IO_TIMEOUT);
                            end else begin
                                mem_en    <= 1'b1;
                                mem_we    <= be_dec;
                                mem_addr  <= addr[31:2];
                                mem_wdata <= wdata_rep;
                            end
                        end
                    end
                end
                S_BUS: begin
                    if (bus_hit || bus_tmo) begin
                        mem_en <= 1'b0;
                        mem_we <= '0;
                        io_sel <= '0;
                        io_we  <= 1'b0;
                        if (bus_hit)
                            rdata <= is_store_q ? 32'h0
                                     : load_ext(ld_op_q, lo_q, is_io_q ? io_word : mem_rdata);
                        else
                            exc_bus <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q - 8'd1;
                    end
                end
                default: begin
                    rdata    <= '0;
                    exc_adel <= 1'b0;
                    exc_ades <= 1'b0;
                    exc_bus  <= 1'b0;
                end
            endcase
        end
    end

endmodule
